// File: rtl/definitions.sv
// Shared types for the BeeF core slice: program counter width and loader FSM types.
package definitions;

   localparam int PC_W = 10;

   typedef logic [PC_W-1:0] PROGRAM_COUNTER;
   typedef logic [15:0]     LOAD_LEN;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      LOAD,
      RUN,
      DONE,
      ERROR
   } LOADER_STATE;

endpackage

// File: rtl/program_loader.sv
// Host-side instruction memory writer: takes a length-prefixed byte stream,
// fills imem from address 0, then releases the core and times its run.
module program_loader
   import definitions::*;
#(
   parameter int ADDR_W  = $bits(PROGRAM_COUNTER),
   parameter int INSTR_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_run,
   input  logic               core_done,
   output logic               busy,
   output logic               finished,
   output logic               error,
   output logic [31:0]        run_cycles
);

   // One past the last address; a full-memory load is legal.
   localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

   LOADER_STATE       state, state_nxt;
   logic [7:0]        len_lo;
   LOAD_LEN           remaining;
   logic [ADDR_W-1:0] addr;
   logic              accept;
   logic [16:0]       len_full;
   logic              len_bad;

   assign accept   = in_valid && in_ready;
   assign len_full = {1'b0, in_data, len_lo};
   assign len_bad  = (len_full == 17'd0) || (len_full > MAX_LEN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start)  state_nxt = LEN_LO;
         LEN_LO: if (accept) state_nxt = LEN_HI;
         LEN_HI: if (accept) state_nxt = len_bad ? ERROR : LOAD;
         LOAD:   if (accept && remaining == 16'd1) state_nxt = RUN;
         RUN:    if (core_done) state_nxt = DONE;
         DONE:   if (start)  state_nxt = LEN_LO;
         ERROR:  if (start)  state_nxt = LEN_LO;
         default:            state_nxt = IDLE;
      endcase
   end

   // Handshake depends on state alone, never on in_valid.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      finished = 1'b0;
      error    = 1'b0;
      case (state)
         LEN_LO, LEN_HI, LOAD: begin in_ready = 1'b1; busy = 1'b1; end
         RUN:                  busy     = 1'b1;
         DONE:                 finished = 1'b1;
         ERROR:                error    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo     <= '0;
         remaining  <= '0;
         addr       <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_run   <= 1'b0;
         run_cycles <= '0;
      end else begin
         imem_we <= 1'b0;
         if (state == LEN_LO && accept) len_lo <= in_data;
         if (state == LEN_HI && accept) begin
            addr      <= '0;
            remaining <= {in_data, len_lo};
         end
         if (state == LOAD && accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= INSTR_W'(in_data);
            addr       <= addr + ADDR_W'(1);
            remaining  <= remaining - 16'd1;
         end
         // Release lags RUN entry by one edge so the final write lands first.
         core_run <= (state == RUN) && !core_done;
         if (core_run && run_cycles != 32'hFFFF_FFFF)
            run_cycles <= run_cycles + 32'd1;
         if (state == DONE && start)
            run_cycles <= '0;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, loads, length limits, stalls, reset mid-load.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [9:0]  imem_addr;
   logic [7:0]  imem_wdata;
   logic        core_run;
   logic        core_done = 1'b0;
   logic        busy, finished, error;
   logic [31:0] run_cycles;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int wr_in_run = 0;
   logic [9:0] wa_q[$];
   logic [7:0] wd_q[$];
   int         wc_q[$];

   program_loader #(.ADDR_W(10), .INSTR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_run(core_run),
      .core_done(core_done), .busy(busy), .finished(finished), .error(error),
      .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   // Log every write performed at an edge, with the edge number.
   always @(posedge clk) begin
      cyc++;
      if (imem_we) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_wdata);
         wc_q.push_back(cyc);
         if (core_run) wr_in_run++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_byte: in_ready got 0 for 50 cycles, required 1");
      end
      @(negedge clk);
   endtask

   task automatic run_done();
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if ({in_ready, imem_we, core_run, busy, finished, error} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 000000", {in_ready, imem_we, core_run, busy, finished, error}); end
      n_checks++; if (imem_addr !== 10'd0 || imem_wdata !== 8'd0 || run_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_data: got addr %h data %h cyc %h required 0", imem_addr, imem_wdata, run_cycles); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_traffic();
      clear_log();
      in_data = 8'h55; in_valid = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got ready %b busy %b required 0 0", in_ready, busy); end
      n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL idle_writes: got %0d required 0", wa_q.size()); end
      in_valid = 1'b0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h77);
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (wa_q.size() !== 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 8'h77) begin n_fail++; $display("FAIL idle_load1: got %0d writes required one (0,77)", wa_q.size()); end
      n_checks++; if (core_run !== 1'b1) begin n_fail++; $display("FAIL idle_run: got %b required 1", core_run); end
      run_done();
      n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL idle_done: got %b required 1", finished); end
   endtask

   task automatic test_basic_load();
      clear_log();
      pulse_start();
      send_byte(8'h03); send_byte(8'h00);
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
      in_valid = 1'b0;
      n_checks++; if (core_run !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_after_last: got run %b ready %b busy %b required 0 0 1", core_run, in_ready, busy); end
      @(negedge clk);
      n_checks++; if (core_run !== 1'b1) begin n_fail++; $display("FAIL basic_release: got %b required 1", core_run); end
      n_checks++; if (wa_q.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d required 3", wa_q.size()); end
      else begin
         n_checks++; if (wa_q[0] !== 10'd0 || wa_q[1] !== 10'd1 || wa_q[2] !== 10'd2) begin n_fail++; $display("FAIL basic_addr: got %h %h %h required 000 001 002", wa_q[0], wa_q[1], wa_q[2]); end
         n_checks++; if (wd_q[0] !== 8'hA1 || wd_q[1] !== 8'hB2 || wd_q[2] !== 8'hC3) begin n_fail++; $display("FAIL basic_data: got %h %h %h required a1 b2 c3", wd_q[0], wd_q[1], wd_q[2]); end
         n_checks++; if (wc_q[1] !== wc_q[0] + 1 || wc_q[2] !== wc_q[1] + 1) begin n_fail++; $display("FAIL basic_b2b: got edges %0d %0d %0d required consecutive", wc_q[0], wc_q[1], wc_q[2]); end
      end
      // core_run rose at edge E; edges E+1..E+10 count, done sampled at E+10.
      repeat (9) @(negedge clk);
      run_done();
      n_checks++; if (run_cycles !== 32'd10) begin n_fail++; $display("FAIL run_count: got %0d required 10", run_cycles); end
      n_checks++; if (finished !== 1'b1 || core_run !== 1'b0) begin n_fail++; $display("FAIL run_done: got finished %b run %b required 1 0", finished, core_run); end
      repeat (3) @(negedge clk);
      n_checks++; if (run_cycles !== 32'd10 || wa_q.size() !== 3) begin n_fail++; $display("FAIL run_frozen: got cycles %0d writes %0d required 10 3", run_cycles, wa_q.size()); end
      n_checks++; if (wr_in_run !== 0) begin n_fail++; $display("FAIL write_during_run: got %0d required 0", wr_in_run); end
      pulse_start();
      n_checks++; if (run_cycles !== 32'd0 || in_ready !== 1'b1 || finished !== 1'b0) begin n_fail++; $display("FAIL restart: got cycles %0d ready %b finished %b required 0 1 0", run_cycles, in_ready, finished); end
   endtask

   task automatic test_len_errors();
      clear_log();
      send_byte(8'h00); send_byte(8'h00);
      in_valid = 1'b0;
      n_checks++; if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL len_zero: got error %b busy %b ready %b required 1 0 0", error, busy, in_ready); end
      pulse_start();
      send_byte(8'h01); send_byte(8'h04);
      in_valid = 1'b0;
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len_401: got %b required 1", error); end
      n_checks++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL len_err_writes: got %0d required 0", wa_q.size()); end
   endtask

   task automatic test_full_memory();
      int bad = 0;
      clear_log();
      pulse_start();
      n_checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL err_restart: got error %b ready %b required 0 1", error, in_ready); end
      send_byte(8'h00); send_byte(8'h04);
      for (int i = 0; i < 1024; i++) send_byte(8'(i));
      in_valid = 1'b0;
      n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL full_run_state: got busy %b ready %b error %b required 1 0 0", busy, in_ready, error); end
      @(negedge clk);
      n_checks++; if (wa_q.size() !== 1024) begin n_fail++; $display("FAIL full_count: got %0d required 1024", wa_q.size()); end
      else begin
         for (int i = 0; i < 1024; i++)
            if (wa_q[i] !== 10'(i) || wd_q[i] !== 8'(i)) bad++;
         n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_contents: got %0d bad writes required 0", bad); end
         n_checks++; if (wa_q[1023] !== 10'h3FF) begin n_fail++; $display("FAIL full_last_addr: got %h required 3ff", wa_q[1023]); end
      end
      n_checks++; if (core_run !== 1'b1) begin n_fail++; $display("FAIL full_release: got %b required 1", core_run); end
      run_done();
      n_checks++; if (run_cycles !== 32'd1) begin n_fail++; $display("FAIL full_run_count: got %0d required 1", run_cycles); end
   endtask

   task automatic test_stalls();
      clear_log();
      pulse_start();
      send_byte(8'h04); send_byte(8'h00);
      send_byte(8'hD0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (wa_q.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d required 4", wa_q.size()); end
      else begin
         n_checks++; if (wa_q[0] !== 10'd0 || wa_q[1] !== 10'd1 || wa_q[2] !== 10'd2 || wa_q[3] !== 10'd3) begin n_fail++; $display("FAIL stall_addr: got %h %h %h %h required 0..3", wa_q[0], wa_q[1], wa_q[2], wa_q[3]); end
         n_checks++; if (wd_q[1] !== 8'hD1 || wd_q[3] !== 8'hD3) begin n_fail++; $display("FAIL stall_data: got %h %h required d1 d3", wd_q[1], wd_q[3]); end
         n_checks++; if (wc_q[1] - wc_q[0] !== 3) begin n_fail++; $display("FAIL stall_gap: got %0d required 3", wc_q[1] - wc_q[0]); end
      end
      run_done();
   endtask

   task automatic test_spurious_done();
      clear_log();
      pulse_start();
      core_done = 1'b1;
      send_byte(8'h03); send_byte(8'h00);
      send_byte(8'hE0); send_byte(8'hE1);
      n_checks++; if (busy !== 1'b1 || finished !== 1'b0) begin n_fail++; $display("FAIL spur_state: got busy %b finished %b required 1 0", busy, finished); end
      core_done = 1'b0;
      send_byte(8'hE2);
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (core_run !== 1'b1 || wa_q.size() !== 3) begin n_fail++; $display("FAIL spur_load: got run %b writes %0d required 1 3", core_run, wa_q.size()); end
      else begin
         n_checks++; if (wa_q[2] !== 10'd2 || wd_q[2] !== 8'hE2) begin n_fail++; $display("FAIL spur_last: got (%h,%h) required (002,e2)", wa_q[2], wd_q[2]); end
      end
      run_done();
      n_checks++; if (finished !== 1'b1 || run_cycles !== 32'd1) begin n_fail++; $display("FAIL spur_done: got finished %b cycles %0d required 1 1", finished, run_cycles); end
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      pulse_start();
      send_byte(8'h05); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      in_valid = 1'b0;
      n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd1) begin n_fail++; $display("FAIL mid_pending: got we %b addr %h required 1 001", imem_we, imem_addr); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if ({in_ready, imem_we, core_run, busy, finished, error} !== 6'b0 || imem_addr !== 10'd0 || run_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset: got flags %b addr %h required 000000 000", {in_ready, imem_we, core_run, busy, finished, error}, imem_addr); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      clear_log();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL reload_count: got %0d required 2", wa_q.size()); end
      else begin
         n_checks++; if (wa_q[0] !== 10'd0 || wa_q[1] !== 10'd1 || wd_q[0] !== 8'h11 || wd_q[1] !== 8'h22) begin n_fail++; $display("FAIL reload_writes: got (%h,%h) (%h,%h) required (000,11) (001,22)", wa_q[0], wd_q[0], wa_q[1], wd_q[1]); end
      end
      run_done();
      n_checks++; if (wr_in_run !== 0) begin n_fail++; $display("FAIL write_during_run_end: got %0d required 0", wr_in_run); end
   endtask

   initial begin
      test_reset();
      test_idle_traffic();
      test_basic_load();
      test_len_errors();
      test_full_memory();
      test_stalls();
      test_spurious_done();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side writer for the BeeF core's instruction memory, the producer on the other end of the fetch path. It accepts a length-prefixed byte stream over a valid/ready handshake and writes each byte into instruction memory at consecutive addresses from 0. It then releases the core, counts cycles until the core raises `done`, and holds the result for the host. It sits beside `top_level`: its write port drives the instruction memory, and its `core_run` output gates the core's reset.

## Interface
- `ADDR_W`, default 10: instruction memory address width; capacity is 2^ADDR_W instructions.
- `INSTR_W`, default 8: instruction word width; equals the host byte width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- `in_data`  in  8  host stream byte.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on an edge where `in_valid` and `in_ready` are both 1.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  INSTR_W  write data.
- `core_run`  out  1  1 releases the core; the core's reset is driven from `~core_run` at top level.
- `core_done`  in  1  the core's `done` output.
- `busy`  out  1  state is not IDLE, DONE or ERROR.
- `finished`  out  1  1 while in DONE.
- `error`  out  1  1 while in ERROR.
- `run_cycles`  out  32  count of cycles during which `core_run` was 1.

## Operation
- **IDLE:** `in_ready`=0. On `start`, go to LEN_LO.
- **LEN_LO:** `in_ready`=1. An accepted byte becomes length[7:0]; go to LEN_HI.
- **LEN_HI:** `in_ready`=1. An accepted byte becomes length[15:8].
  - If length==0 or length>2^ADDR_W, go to ERROR.
  - Otherwise set addr=0, remaining=length, and go to LOAD.
- **LOAD:** `in_ready`=1.
  - Each accepted byte issues one registered write: `imem_addr`=addr, `imem_wdata`=byte.
  - addr increments and remaining decrements on each accepted byte.
  - Acceptance of the last byte (remaining==1) moves the state to RUN.
- **RUN:** `in_ready`=0.
  - `run_cycles` increments on every edge where `core_run`=1 and saturates at 0xFFFFFFFF.
  - `core_done` sampled high goes to DONE and clears `core_run` on that same edge.
- **DONE:** `finished`=1; `run_cycles` is frozen. `start` clears `run_cycles` and goes to LEN_LO.
- **ERROR:** `error`=1, `in_ready`=0. `start` goes to LEN_LO.
- **Ignored inputs:**
  - `core_done` outside RUN is ignored.
  - `in_valid` is ignored while `in_ready`=0; no byte is consumed.
  - `start` in any other state is ignored.
- **Reset values:** all outputs 0 (`in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `core_run`, `busy`, `finished`, `error`, `run_cycles`); state IDLE.

## Timing
- **Handshake:** `in_ready` is a function of state only and never depends on `in_valid`. The host may hold `in_valid` across any number of cycles.
- **Write latency:** a byte accepted at edge k is presented as `imem_we`=1 with its address and data during cycle k+1, and is written at edge k+1. `imem_we` is 0 in every cycle without a preceding accept.
- **Back-to-back bytes** produce back-to-back writes at one byte per cycle.
- **Core release:** `core_run` rises at edge k+1 after the last accept at edge k. The core therefore never runs before the final write completes, and no write occurs while `core_run`=1.
- **Counting:** `core_done` high for 1 cycle suffices. `run_cycles` counts through the edge that samples `core_done`.
- **Reset mid-operation:** `reset` low forces `core_run`=0 and `imem_we`=0 immediately (asynchronous). The next load restarts at address 0; partially written memory is not cleared.
- **Full memory:** length=2^ADDR_W is legal. addr wraps to 0 only after the final write, and that wrapped value is never used.

## Structure
- **`definitions` package:** add the `LOADER_STATE` enum (IDLE, LEN_LO, LEN_HI, LOAD, RUN, DONE, ERROR) and a 16-bit `LOAD_LEN` typedef.
- **Address width:** `imem_addr` width must match the package's `PROGRAM_COUNTER` width.
- **Sub-modules:** none. The block is a single FSM with address, remaining and cycle counters.

## Test plan
- **Basic load:** length bytes 0x03,0x00 then A1,B2,C3 back-to-back → writes (0,A1),(1,B2),(2,C3) on consecutive cycles; `core_run` rises one cycle after the last write; no writes thereafter.
- **Run and restart:** `core_done` pulsed after 10 cycles of `core_run`=1 → `run_cycles`=10, `finished`=1, `core_run`=0. A new `start` clears `run_cycles` to 0 and enters LEN_LO.
- **Length boundaries (ADDR_W=10):**
  - length 0x0000 → `error`=1.
  - length 0x0401 → `error`=1.
  - length 0x0400 → 1024 writes, last address 0x3FF, then RUN.
- **Stalls and idle traffic:** `in_valid` toggling 1,0,0,1 during LOAD → writes occur only after accepted bytes; addresses stay contiguous. `in_valid` held high in IDLE without `start` → no byte consumed.
- **Reset mid-load:** `reset` low after 2 of 5 bytes → all outputs 0 immediately. A subsequent load of 2 bytes writes addresses 0 and 1.
- **Spurious done:** `core_done`=1 during LOAD → ignored; the load completes normally.
